area_ring_scanner: RTL and testbench

- Parametrised successor to the fixed left-edge area classifier for the background LED matrix.
- Autonomously scans the whole ROWS x COLS matrix in row-major order.
- For every pixel, emits a ring level measuring its distance from a runtime-programmable anchor on any of the four edges.
- Output is a valid/ready pixel stream feeding the LED colour/brightness pipeline.

---
 rtl/area_ring_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_area_ring_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/area_ring_scanner.sv
// Row-major scanner for the ROWS x COLS LED matrix. Each pixel is tagged with its
// ring level around an edge anchor and delivered on a registered valid/ready stream.
module area_ring_scanner #(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int RW    = 7,
    parameter int CW    = 7,
    parameter int RINGS = 3,
    parameter int LW    = 2,
    parameter int PW    = (RW > CW) ? RW : CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    input  logic [1:0]    cfg_side,
    input  logic [PW-1:0] cfg_pos,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [RW-1:0] pix_row,
    output logic [CW-1:0] pix_col,
    output logic [LW-1:0] pix_level,
    output logic          pix_last,
    output logic          done
);

    localparam int DW = PW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_e;
    typedef enum logic [1:0] {
        SIDE_LEFT   = 2'd0,
        SIDE_RIGHT  = 2'd1,
        SIDE_TOP    = 2'd2,
        SIDE_BOTTOM = 2'd3
    } side_e;

    state_e        r_state;
    state_e        w_next_state;
    side_e         r_side;
    logic [PW-1:0] r_pos;
    logic [RW-1:0] r_cnt_row;
    logic [CW-1:0] r_cnt_col;
    logic          r_pix_valid;
    logic [RW-1:0] r_pix_row;
    logic [CW-1:0] r_pix_col;
    logic [LW-1:0] r_pix_level;
    logic          r_pix_last;
    logic          r_done;

    logic          w_out_free;
    logic          w_at_last;
    logic          w_issue;
    logic          w_finish;
    logic          w_abort;
    logic [DW-1:0] w_row_x;
    logic [DW-1:0] w_col_x;
    logic [DW-1:0] w_pos_x;
    logic [DW-1:0] w_depth;
    logic [DW-1:0] w_off;
    logic [DW-1:0] w_dist;
    logic [LW-1:0] w_level;

    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // One extra bit keeps |coord - pos| exact even for an out-of-range anchor.
    assign w_row_x = DW'(r_cnt_row);
    assign w_col_x = DW'(r_cnt_col);
    assign w_pos_x = DW'(r_pos);

    always_comb begin
        w_depth = '0;
        w_off   = '0;
        case (r_side)
            SIDE_LEFT: begin
                w_depth = w_col_x;
                w_off   = abs_diff(w_row_x, w_pos_x);
            end
            SIDE_RIGHT: begin
                w_depth = DW'(COLS - 1) - w_col_x;
                w_off   = abs_diff(w_row_x, w_pos_x);
            end
            SIDE_TOP: begin
                w_depth = w_row_x;
                w_off   = abs_diff(w_col_x, w_pos_x);
            end
            default: begin
                w_depth = DW'(ROWS - 1) - w_row_x;
                w_off   = abs_diff(w_col_x, w_pos_x);
            end
        endcase
        w_dist  = (w_depth > w_off) ? w_depth : w_off;
        w_level = (w_dist < DW'(RINGS)) ? LW'(w_dist + DW'(1)) : '0;
    end

    assign w_out_free = !r_pix_valid || pix_ready;
    assign w_at_last  = (r_cnt_row == RW'(ROWS - 1)) && (r_cnt_col == CW'(COLS - 1));
    assign w_abort    = abort && (r_state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_out_free) begin
                    w_issue = 1'b1;
                    if (w_at_last) begin
                        w_next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (r_pix_valid && pix_ready) begin
                    w_finish     = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Config is only writable in IDLE so a scan always sees one consistent anchor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_side <= SIDE_LEFT;
            r_pos  <= PW'(1);
        end else if (r_state == ST_IDLE && cfg_valid) begin
            r_side <= side_e'(cfg_side);
            r_pos  <= cfg_pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_row <= '0;
            r_cnt_col <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_cnt_row <= '0;
            r_cnt_col <= '0;
        end else if (w_issue) begin
            if (r_cnt_col == CW'(COLS - 1)) begin
                r_cnt_col <= '0;
                r_cnt_row <= w_at_last ? '0 : r_cnt_row + 1'b1;
            end else begin
                r_cnt_col <= r_cnt_col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_valid <= 1'b0;
            r_pix_row   <= '0;
            r_pix_col   <= '0;
            r_pix_level <= '0;
            r_pix_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_abort) begin
                r_pix_valid <= 1'b0;
                r_pix_last  <= 1'b0;
            end else if (w_issue) begin
                r_pix_valid <= 1'b1;
                r_pix_row   <= r_cnt_row;
                r_pix_col   <= r_cnt_col;
                r_pix_level <= w_level;
                r_pix_last  <= w_at_last;
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
                r_pix_last  <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign pix_valid = r_pix_valid;
    assign pix_row   = r_pix_row;
    assign pix_col   = r_pix_col;
    assign pix_level = r_pix_level;
    assign pix_last  = r_pix_last;
    assign done      = r_done;

endmodule

// File: tb/tb_area_ring_scanner.sv
// Self-checking bench for area_ring_scanner on an 8x8 matrix: directed scans on every
// edge, random backpressure and configs, abort and asynchronous reset mid-scan.
module tb_area_ring_scanner;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int RW    = 7;
    localparam int CW    = 7;
    localparam int RINGS = 3;
    localparam int LW    = 2;
    localparam int PW    = 7;
    localparam int NPIX  = ROWS * COLS;

    logic          clk;
    logic          rst_n;
    logic          cfg_valid;
    logic [1:0]    cfg_side;
    logic [PW-1:0] cfg_pos;
    logic          start;
    logic          abort;
    logic          busy;
    logic          pix_valid;
    logic          pix_ready;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic [LW-1:0] pix_level;
    logic          pix_last;
    logic          done;

    int errors = 0;
    int checks = 0;
    int lv[NPIX];

    int t1_idx[8] = '{24, 16, 33, 25, 10, 40, 27, 0};
    int t1_exp[8] = '{1, 2, 2, 2, 3, 3, 0, 0};

    area_ring_scanner #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW),
        .RINGS(RINGS),
        .LW   (LW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_side (cfg_side),
        .cfg_pos  (cfg_pos),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_row  (pix_row),
        .pix_col  (pix_col),
        .pix_level(pix_level),
        .pix_last (pix_last),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ring level straight from the geometric definition: Chebyshev-style distance
    // from the anchor, levels 1..RINGS inside, 0 outside.
    function automatic int ref_level(input int side, input int pos, input int r, input int c);
        int depth;
        int off;
        int d;
        depth = 0;
        off   = 0;
        case (side)
            0: begin depth = c;            off = (r > pos) ? r - pos : pos - r; end
            1: begin depth = COLS - 1 - c; off = (r > pos) ? r - pos : pos - r; end
            2: begin depth = r;            off = (c > pos) ? c - pos : pos - c; end
            default: begin depth = ROWS - 1 - r; off = (c > pos) ? c - pos : pos - c; end
        endcase
        d = (depth > off) ? depth : off;
        return (d < RINGS) ? d + 1 : 0;
    endfunction

    // Runs one scan from IDLE. side/pos are the config the scan is expected to use;
    // load_cfg=0 relies on the retained config. abort_at/midcfg_at/rst_at (>=0) inject
    // an event when that many pixels have been accepted.
    task automatic run_scan(input int side, input int pos, input bit load_cfg, input bit rnd_ready,
                            input int abort_at, input int midcfg_at, input int rst_at,
                            input string tag);
        int n = 0;
        int cycles = 0;
        int first_hs = -1;
        int last_hs = -1;
        bit finished = 0;
        bit exp_done = 0;
        bit exp_next = 0;
        bit prev_stall = 0;
        bit mid_done = 0;
        bit hs;
        logic [31:0] prev_bus = '0;
        for (int i = 0; i < NPIX; i++) lv[i] = -1;

        cfg_valid = load_cfg;
        cfg_side  = 2'(side);
        cfg_pos   = 7'(pos);
        start     = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        start     = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 1);
        check({tag, "_no_valid_at_start"}, 32'(pix_valid), 0);

        while (!finished && cycles < 1000) begin
            cycles++;
            cfg_valid = 1'b0;
            start     = 1'b0;
            check({tag, "_done"}, 32'(done), 32'(exp_done));
            if (exp_done) begin
                finished = 1;
                check({tag, "_idle_after_done"}, 32'({busy, pix_valid}), 0);
            end else begin
                if (prev_stall)
                    check({tag, "_stall_hold"},
                          32'({pix_valid, pix_last, pix_level, pix_row, pix_col}), prev_bus);
                pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

                if (abort_at >= 0 && n == abort_at && pix_valid) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check({tag, "_abort_valid"}, 32'({pix_valid, pix_last}), 0);
                    check({tag, "_abort_busy"}, 32'(busy), 0);
                    check({tag, "_abort_done"}, 32'(done), 0);
                    @(negedge clk);
                    check({tag, "_abort_no_done_later"}, 32'({done, busy}), 0);
                    return;
                end

                if (rst_at >= 0 && n == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check({tag, "_rst_outputs"},
                          32'({busy, pix_valid, done, pix_last, pix_level, pix_row, pix_col}), 0);
                    #4 rst_n = 1'b1;
                    @(negedge clk);
                    check({tag, "_after_rst_idle"}, 32'({busy, pix_valid, done}), 0);
                    return;
                end

                if (midcfg_at >= 0 && n == midcfg_at && !mid_done) begin
                    mid_done  = 1;
                    cfg_valid = 1'b1;
                    cfg_side  = 2'd2;
                    cfg_pos   = 7'd0;
                    start     = 1'b1;
                end

                hs = pix_valid && pix_ready;
                exp_next = 0;
                if (hs) begin
                    check({tag, "_row"}, 32'(pix_row), n / COLS);
                    check({tag, "_col"}, 32'(pix_col), n % COLS);
                    check({tag, "_level"}, 32'(pix_level), ref_level(side, pos, n / COLS, n % COLS));
                    check({tag, "_last"}, 32'(pix_last), 32'(n == NPIX - 1));
                    lv[n] = int'(pix_level);
                    if (first_hs < 0) first_hs = cycles;
                    if (n == NPIX - 1) begin
                        last_hs  = cycles;
                        exp_next = 1;
                    end
                    n++;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_bus   = 32'({pix_valid, pix_last, pix_level, pix_row, pix_col});
                @(negedge clk);
                exp_done = exp_next;
            end
        end

        check({tag, "_completed"}, 32'(finished), 1);
        check({tag, "_pixel_count"}, n, NPIX);
        if (!rnd_ready) check({tag, "_back_to_back"}, last_hs - first_hs, NPIX - 1);
        pix_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_single_done_no_restart"}, 32'({done, busy, pix_valid}), 0);
        end
    endtask

    initial begin
        int sum;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_side  = 2'd0;
        cfg_pos   = 7'd0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({busy, pix_valid, done, pix_last, pix_level, pix_row, pix_col}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_idle", 32'({busy, pix_valid, done}), 0);

        // Left edge, full throughput, plus hand-derived spot levels.
        run_scan(0, 3, 1, 0, -1, -1, -1, "t1");
        for (int i = 0; i < 8; i++) check("t1_spot", lv[t1_idx[i]], t1_exp[i]);

        // Same config under random backpressure.
        run_scan(0, 3, 1, 1, -1, -1, -1, "t2");
        for (int i = 0; i < 8; i++) check("t2_spot", lv[t1_idx[i]], t1_exp[i]);

        run_scan(2, 0, 1, 1, -1, -1, -1, "t3_top");
        check("t3_top_00", lv[0], 1);
        check("t3_top_02", lv[2], 3);
        check("t3_top_21", lv[17], 3);
        check("t3_top_03", lv[3], 0);
        run_scan(3, 7, 1, 0, -1, -1, -1, "t3_bottom");
        check("t3_bottom_77", lv[63], 1);
        check("t3_bottom_66", lv[54], 2);
        run_scan(1, 0, 1, 0, -1, -1, -1, "t3_right");
        check("t3_right_07", lv[7], 1);
        check("t3_right_16", lv[14], 2);
        run_scan(0, 100, 1, 1, -1, -1, -1, "t3_far");
        sum = 0;
        for (int i = 0; i < NPIX; i++) sum += lv[i];
        check("t3_far_all_zero", sum, 0);

        // Config and start mid-scan are both ignored.
        run_scan(0, 3, 1, 1, -1, 30, -1, "t4");

        // Abort at pixel 20, then restart with the retained config.
        run_scan(0, 3, 1, 0, 20, -1, -1, "t5");
        run_scan(0, 3, 0, 0, -1, -1, -1, "t5_restart");
        check("t5_restart_30", lv[24], 1);

        // Async reset mid-scan restores left/pos=1.
        run_scan(2, 4, 1, 1, -1, -1, 10, "t6");
        run_scan(0, 1, 0, 0, -1, -1, -1, "t6_after");
        check("t6_after_10", lv[8], 1);

        for (int k = 0; k < 4; k++) begin
            int s;
            int p;
            s = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 10));
            run_scan(s, p, 1, 1, -1, -1, -1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
